// File: rtl/fa_seq_pkg.sv
// Shared types and default sizing for the bit-serial-by-slice adder sequencer.
package fa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_WORDS = 4;

endpackage

// File: rtl/fa_nbit_ripple.sv
// Purely combinational N-bit ripple-carry adder slice.
module fa_nbit_ripple #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic w_c;

    // Carry is threaded bit by bit: bit 0 takes c_in, bit i takes bit i-1's carry-out.
    always_comb begin
        w_c = c_in;
        sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ w_c;
            w_c    = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        c_out = w_c;
    end

endmodule

// File: rtl/fa_slice_sequencer.sv
// Adds two W=N*WORDS bit operands by reusing one N-bit ripple slice over WORDS cycles.
module fa_slice_sequencer
    import fa_seq_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned WORDS = DEF_WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout
);

    localparam int unsigned W  = N * WORDS;
    localparam int unsigned KW = $clog2(WORDS + 1);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_carry;
    logic          r_cout;
    logic [KW-1:0] r_k;
    logic [N-1:0]  w_sl_a;
    logic [N-1:0]  w_sl_b;
    logic [N-1:0]  w_sl_sum;
    logic          w_sl_cout;
    logic          w_accept;
    logic          w_last;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_state == RUN) && (r_k == K_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_comb begin
        w_sl_a = '0;
        w_sl_b = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (r_k == KW'(i)) begin
                w_sl_a = r_a[i*N +: N];
                w_sl_b = r_b[i*N +: N];
            end
        end
    end

    fa_nbit_ripple #(.N(N)) u_slice (
        .a     (w_sl_a),
        .b     (w_sl_b),
        .c_in  (r_carry),
        .sum   (w_sl_sum),
        .c_out (w_sl_cout)
    );

    // k holds at the last slice rather than stepping to WORDS, so it never leaves 0..WORDS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_k     <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_k     <= '0;
        end else if (r_state == RUN) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                if (r_k == KW'(i)) r_sum[i*N +: N] <= w_sl_sum;
            end
            r_carry <= w_sl_cout;
            if (w_last) r_cout <= w_sl_cout;
            else        r_k    <= r_k + KW'(1);
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_fa_slice_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a timestamp-based model.
module tb_fa_slice_sequencer;

    localparam int unsigned N     = 4;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    fa_slice_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an operation is busy from its acceptance edge; its result is due WORDS edges later.
    int           cyc      = 0;
    bit           m_busy   = 1'b0;
    bit           m_zero   = 1'b1;
    int           m_acc    = 0;
    int           m_n_acc  = 0;
    logic [W-1:0] m_sum    = '0;
    logic         m_cout   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_zero = 1'b1;
        end else begin
            if (m_busy && (cyc - m_acc >= int'(WORDS))) begin
                if (out_ready) m_busy = 1'b0;
                cyc++;
            end else begin
                cyc++;
                if (!m_busy && in_valid) begin
                    m_busy           = 1'b1;
                    m_zero           = 1'b0;
                    m_acc            = cyc;
                    {m_cout, m_sum}  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                    m_n_acc++;
                end
            end
        end
    end

    int           acc_q[$];
    logic [W:0]   res_q[$];

    always @(negedge clk) begin
        bit exp_ov;
        if (rst_n) begin
            exp_ov = m_busy && (cyc - m_acc >= int'(WORDS));
            check("in_ready", 32'(in_ready), 32'(!m_busy));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) begin
                check("sum", 32'(sum), 32'(m_sum));
                check("cout", 32'(cout), 32'(m_cout));
            end else if (m_zero) begin
                check("sum_after_reset", 32'(sum), 32'd0);
                check("cout_after_reset", 32'(cout), 32'd0);
            end
            if (out_valid && out_ready) res_q.push_back({cout, sum});
            if (in_valid && in_ready)   acc_q.push_back(cyc + 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check(nm, 32'(seen), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  base;
        bit  sw;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Full-width carry propagation and latency
        tick();
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_ov("t1_timeout");
        check("t1_latency", 32'(cyc - acc_q[$]), 32'd4);
        check("t1_sum", 32'(sum), 32'h0000);
        check("t1_cout", 32'(cout), 32'd1);
        tick(); out_ready = 1'b1;
        tick(); out_ready = 1'b0;

        // Held result under backpressure
        tick();
        a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_ov("t2_timeout");
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            check("t2_sum_hold", 32'(sum), 32'h5556);
            check("t2_cout_hold", 32'(cout), 32'd0);
            check("t2_in_ready_hold", 32'(in_ready), 32'd0);
            check("t2_out_valid_hold", 32'(out_valid), 32'd1);
        end
        tick(); out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        @(negedge clk);
        check("t2_in_ready_after", 32'(in_ready), 32'd1);

        // New request while busy must be ignored
        tick();
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'hAAAA; b = 16'hAAAA;
        wait_ov("t3_timeout");
        check("t3_sum", 32'(sum), 32'h3333);
        check("t3_cout", 32'(cout), 32'd0);
        tick(); in_valid = 1'b0; out_ready = 1'b1;
        tick(); out_ready = 1'b0;

        // Reset in the second RUN cycle discards the operation
        tick();
        a = 16'hF0F0; b = 16'h0F0F; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t4_rst_sum", 32'(sum), 32'd0);
        check("t4_rst_cout", 32'(cout), 32'd0);
        check("t4_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_no_spurious_valid", 32'(out_valid), 32'd0);
            check("t4_in_ready", 32'(in_ready), 32'd1);
        end

        // Back-to-back issue at the minimum interval
        tick();
        acc_q.delete();
        res_q.delete();
        a = 16'h8000; b = 16'h8000; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        sw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (acc_q.size() >= 1 && !sw) begin
                a  = 16'h0F0F; b = 16'h00F1;
                sw = 1'b1;
            end
            if (acc_q.size() >= 2) break;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 30 && res_q.size() < 2; i++) tick();
        check("t5_results", 32'(res_q.size()), 32'd2);
        check("t5_accepts", 32'(acc_q.size()), 32'd2);
        if (res_q.size() >= 2 && acc_q.size() >= 2) begin
            check("t5_res0", 32'(res_q[0]), 32'h1_0000);
            check("t5_res1", 32'(res_q[1]), 32'h0_1000);
            check("t5_interval", 32'(acc_q[1] - acc_q[0]), 32'd6);
        end
        out_ready = 1'b0;

        // Randomized traffic with random backpressure
        base = m_n_acc;
        for (int c = 0; c < 40000 && (m_n_acc - base) < 1000; c++) begin
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rand_ops", 32'(m_n_acc - base), 32'd1000);
        repeat (10) tick();
        @(negedge clk);
        check("final_idle", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fa_slice_sequencer.md
FA_SLICE_SEQUENCER -- requirements
Module: fa_slice_sequencer

Interface
Parameters:
REQ-001 SHALL have parameter N, default 4: bit width of the shared full-adder slice.
REQ-002 SHALL have parameter WORDS, default 4: number of slices per operand; operand width W = N*WORDS.
Ports:
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port a  input  W  operand A, sampled on acceptance.
REQ-008 SHALL have port b  input  W  operand B, sampled on acceptance.
REQ-009 SHALL have port cin  input  1  carry-in to slice 0, sampled on acceptance.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port sum  output  W  result A+B+cin modulo 2^W.
REQ-013 SHALL have port cout  output  1  carry out of bit W-1.
REQ-014 SHALL have a single clock; reset SHALL be asynchronous and active-low.

Function
REQ-015 SHALL use FSM states IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; a, b, cin captured into registers, slice index k cleared to 0, state to RUN.
REQ-018 In RUN, each cycle SHALL drive one N-bit ripple slice with a[k*N +: N], b[k*N +: N], carry-in = carry register; on the edge, sum[k*N +: N] and carry register SHALL be updated and k incremented.
REQ-019 Within the slice, bit 0 carry-in SHALL be the carry register and bit i carry-in SHALL be bit i-1 carry-out.
REQ-020 When k = WORDS-1 is processed, state SHALL go to DONE; out_valid SHALL rise exactly WORDS edges after the acceptance edge.
REQ-021 k SHALL be ceil(log2(WORDS+1)) bits and SHALL never wrap past WORDS-1.
REQ-022 In DONE, sum and cout SHALL hold stable until out_valid=1 and out_ready=1 on a rising edge, after which state SHALL return to IDLE.
REQ-023 in_valid while not IDLE SHALL be ignored; operands SHALL not change mid-operation.
REQ-024 Completion and new acceptance SHALL NOT occur in the same cycle; minimum issue interval = WORDS+2 cycles.
REQ-025 WORDS=1 SHALL be legal: one RUN cycle, then DONE.
REQ-026 sum and cout SHALL be registered outputs; no combinational path from inputs to sum/cout.

Reset
REQ-027 rst_n=0 SHALL, asynchronously, force state IDLE, k=0, carry register 0, sum=0, cout=0, out_valid=0, in_ready=1 on release.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid SHALL follow reset release without a new acceptance.

Structure
REQ-029 Package fa_seq_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and default constants for N and WORDS.
REQ-030 The N-bit ripple slice SHALL be a separate combinational sub-module fa_nbit_ripple (ports a, b, c_in, sum, c_out, width N); the sequencer instantiates exactly one.

Verification (N=4, WORDS=4)
REQ-031 Accept a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, out_valid 4 edges after acceptance.
REQ-032 a=0x1234, b=0x4321, cin=1 with out_ready held 0 for 5 cycles -> sum=0x5556, cout=0 stable throughout, in_ready=0 until handshake.
REQ-033 in_valid=1 with a=0xAAAA during RUN -> ignored; in-flight result unchanged.
REQ-034 rst_n pulsed low at second RUN cycle -> outputs zero immediately, in_ready=1 after release, no spurious out_valid.
REQ-035 Back-to-back: in_valid held 1, out_ready held 1, operands 0x8000+0x8000 then 0x0F0F+0x00F1 -> results (0x0000, 1) then (0x1000, 0), issue interval 6 cycles.
REQ-036 Random self-check: 1000 operand pairs vs. reference A+B+cin, random out_ready backpressure.
